// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: scanner state enum, key code width, column drive reset pattern,
// and the row-priority encoder used when several rows read low at once.
package keypad_pkg;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } kp_state_e;

    localparam int          KEY_CODE_W = 4;
    localparam logic [3:0]  COL_N_RST  = 4'b1110;

    // Lowest-index asserted row wins; rows_low is active-high here.
    function automatic logic [1:0] row_prio_enc(input logic [3:0] rows_low);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (rows_low[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running divider producing a one-cycle scan enable every SCAN_DIV clocks.
// Latency: tick is high while the counter sits at SCAN_DIV-1 (combinational decode).
// Backpressure: none; tick is an unconditional periodic enable.
//
// Ports:
//   clk  - system clock
//   rst  - asynchronous active-high reset, counter returns to 0
//   tick - high for one clk cycle out of every SCAN_DIV
module scan_tick_gen #(
    parameter int SCAN_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int               CW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0]    LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: column drive, synchronized row sense, debounce, key report.
// Latency: detect tick plus DEBOUNCE_SCANS ticks to key_valid; 2-cycle row synchronizer.
// Backpressure: none; key_valid is a one-cycle strobe the consumer must take when seen.
//
// Ports:
//   clk       - system clock
//   rst       - asynchronous active-high reset
//   col_n     - column drive, active-low, one column low at a time
//   row_n     - row sense, active-low, pulled up, asynchronous to clk
//   key_code  - {row[1:0], col[1:0]} of the last accepted key, held
//   key_valid - one-cycle strobe on acceptance (and on auto-repeat)
//   key_down  - high from acceptance until the release is debounced
//
// Build option: define KEYPAD_REPEAT_EN to re-strobe key_valid every
// REPEAT_SCANS ticks while a key stays held.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_SCANS   = 250
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [3:0]            col_n,
    input  logic [3:0]            row_n,
    output logic [KEY_CODE_W-1:0] key_code,
    output logic                  key_valid,
    output logic                  key_down
);

    if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 1 || REPEAT_SCANS < 1) begin : g_param_check
        $error("keypad_scan: SCAN_DIV >= 4, DEBOUNCE_SCANS >= 1, REPEAT_SCANS >= 1");
    end

    localparam int            DW       = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_SCANS);

    // Row synchronizer; idle (all high) is the reset value so no phantom press.
    logic [3:0] row_s1_q;
    logic [3:0] row_s2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_s1_q <= 4'hF;
            row_s2_q <= 4'hF;
        end else begin
            row_s1_q <= row_n;
            row_s2_q <= row_s1_q;
        end
    end

    logic tick;

    scan_tick_gen #(
        .SCAN_DIV (SCAN_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    kp_state_e             state_q,     state_d;
    logic [1:0]            col_idx_q,   col_idx_d;
    logic [3:0]            col_n_q,     col_n_d;
    logic [3:0]            row_lat_q,   row_lat_d;
    logic [DW-1:0]         deb_cnt_q,   deb_cnt_d;
    logic [KEY_CODE_W-1:0] key_code_q,  key_code_d;
    logic                  key_valid_q, key_valid_d;
    logic                  key_down_q,  key_down_d;

    logic          rows_idle;
    logic [1:0]    col_adv;
    logic [DW-1:0] deb_inc;

    assign rows_idle = &row_s2_q;
    assign col_adv   = col_idx_q + 2'd1;
    assign deb_inc   = deb_cnt_q + DW'(1);

`ifdef KEYPAD_REPEAT_EN
    localparam int            RW       = $clog2(REPEAT_SCANS + 1);
    localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_SCANS);

    // Only cleared on entry from DEBOUNCE, so a brief HELD/RELEASE bounce
    // does not restart the repeat interval.
    logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
    logic [RW-1:0] rpt_inc;

    assign rpt_inc = rpt_cnt_q + RW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpt_cnt_q <= '0;
        end else begin
            rpt_cnt_q <= rpt_cnt_d;
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        col_idx_d   = col_idx_q;
        row_lat_d   = row_lat_q;
        deb_cnt_d   = deb_cnt_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_down_d  = key_down_q;
`ifdef KEYPAD_REPEAT_EN
        rpt_cnt_d   = rpt_cnt_q;
`endif

        if (tick) begin
            case (state_q)
                ST_SCAN: begin
                    if (rows_idle) begin
                        col_idx_d = col_adv;
                    end else begin
                        row_lat_d = row_s2_q;
                        deb_cnt_d = '0;
                        state_d   = ST_DEBOUNCE;
                    end
                end

                ST_DEBOUNCE: begin
                    if (row_s2_q != row_lat_q) begin
                        col_idx_d = col_adv;
                        state_d   = ST_SCAN;
                    end else if (deb_inc == DEB_LAST) begin
                        key_code_d  = {row_prio_enc(~row_lat_q), col_idx_q};
                        key_valid_d = 1'b1;
                        key_down_d  = 1'b1;
                        state_d     = ST_HELD;
`ifdef KEYPAD_REPEAT_EN
                        rpt_cnt_d   = '0;
`endif
                    end else begin
                        deb_cnt_d = deb_inc;
                    end
                end

                ST_HELD: begin
                    // A different non-idle pattern is deliberately ignored here.
                    if (rows_idle) begin
                        deb_cnt_d = '0;
                        state_d   = ST_RELEASE;
                    end
`ifdef KEYPAD_REPEAT_EN
                    else if (rpt_inc == RPT_LAST) begin
                        key_valid_d = 1'b1;
                        rpt_cnt_d   = '0;
                    end else begin
                        rpt_cnt_d = rpt_inc;
                    end
`endif
                end

                ST_RELEASE: begin
                    if (!rows_idle) begin
                        state_d = ST_HELD;
                    end else if (deb_inc == DEB_LAST) begin
                        key_down_d = 1'b0;
                        col_idx_d  = col_adv;
                        state_d    = ST_SCAN;
                    end else begin
                        deb_cnt_d = deb_inc;
                    end
                end

                default: begin
                    state_d = ST_SCAN;
                end
            endcase
        end

        // Registered column drive so the board pins never see decode glitches.
        col_n_d = 4'b1111 ^ (4'b0001 << col_idx_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_SCAN;
            col_idx_q   <= 2'd0;
            col_n_q     <= COL_N_RST;
            row_lat_q   <= 4'hF;
            deb_cnt_q   <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_idx_q   <= col_idx_d;
            col_n_q     <= col_n_d;
            row_lat_q   <= row_lat_d;
            deb_cnt_q   <= deb_cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_down_q  <= key_down_d;
        end
    end

    assign col_n     = col_n_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_down  = key_down_q;

endmodule
